// File: rtl/regfile_dump.sv
// regfile_dump: scans a register file through a dedicated read port and
// streams each (address, data) entry out over a valid/ready handshake.
// A one-cycle start begins a scan; a one-cycle done marks its end.
// Optional build macro: REGDUMP_SKIP_ZERO_EN suppresses zero-valued entries.
module regfile_dump #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] SEND = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]        state;
   logic [1:0]        state_next;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_next;
   logic              capture;
   logic              last_ptr;

   assign last_ptr = (ptr == {ADDR_W{1'b1}});

   // The read port always follows the scan pointer, so the register file
   // presents the entry for the current address combinationally.
   assign rf_raddr = ptr;

   // Next-state and pointer logic; abort overrides every other decision.
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               ptr_next   = '0;
               state_next = READ;
            end
         end
         READ: begin
`ifdef REGDUMP_SKIP_ZERO_EN
            if (rf_rdata == '0) begin
               if (last_ptr) begin
                  state_next = DONE;
               end else begin
                  ptr_next = ptr + ADDR_W'(1);
               end
            end else begin
               capture    = 1'b1;
               state_next = SEND;
            end
`else
            capture    = 1'b1;
            state_next = SEND;
`endif
         end
         SEND: begin
            if (out_ready) begin
               if (last_ptr) begin
                  state_next = DONE;
               end else begin
                  ptr_next   = ptr + ADDR_W'(1);
                  state_next = READ;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (abort) begin
         state_next = IDLE;
         ptr_next   = ptr;
         capture    = 1'b0;
      end
   end

   // State, pointer and registered outputs; flags are decoded from the
   // next state so they are aligned with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         out_addr  <= '0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_next;
         ptr       <= ptr_next;
         out_valid <= (state_next == SEND);
         busy      <= (state_next == READ) || (state_next == SEND);
         done      <= (state_next == DONE);
         if (capture) begin
            out_addr <= ptr;
            out_data <= rf_rdata;
            out_last <= last_ptr;
         end
      end
   end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: scoreboard bench for regfile_dump. Stimulus pushes the
// expected stream entries into a queue; a monitor pops and compares on every
// handshake and also watches stability under backpressure and done timing.
module tb_regfile_dump;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              last;
   } entry_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              out_ready = 1'b0;
   logic [ADDR_W-1:0] rf_raddr;
   logic [DATA_W-1:0] rf_rdata;
   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] regs [0:31];

   entry_t expQ[$];
   int     vectors = 0;
   int     miscompares = 0;
   int     cycleCount = 0;
   int     doneCount = 0;
   int     lastHsCycle = -10;
   int     lastDoneCycle = -10;
   int     startCycle = 0;
   bit     checkDoneTiming = 1'b0;

   regfile_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .abort(abort),
      .rf_raddr(rf_raddr),
      .rf_rdata(rf_rdata),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_addr(out_addr),
      .out_data(out_data),
      .out_last(out_last),
      .busy(busy),
      .done(done)
   );

   // Combinational register file model
   assign rf_rdata = regs[rf_raddr];

   // Clock generation
   always #5 clk = ~clk;

   // Cycle counter, stepped on each rising edge
   initial begin
      forever begin
         @(posedge clk);
         cycleCount++;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   // Monitor: pops expected entries on handshakes and checks stability,
   // done/valid exclusivity and done latency
   initial begin
      entry_t            e;
      bit                prevStall;
      logic [ADDR_W-1:0] prevAddr;
      logic [DATA_W-1:0] prevData;
      logic              prevLast;
      prevStall = 1'b0;
      prevAddr  = '0;
      prevData  = '0;
      prevLast  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevStall = 1'b0;
         end else begin
            if (prevStall && out_valid) begin
               checkOutput("stall addr", 64'(out_addr), 64'(prevAddr));
               checkOutput("stall data", 64'(out_data), 64'(prevData));
               checkOutput("stall last", 64'(out_last), 64'(prevLast));
            end
            if (out_valid && out_ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected entry", 64'(out_addr), 64'hFFFF);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("entry addr", 64'(out_addr), 64'(e.addr));
                  checkOutput("entry data", 64'(out_data), 64'(e.data));
                  checkOutput("entry last", 64'(out_last), 64'(e.last));
                  if (out_last) lastHsCycle = cycleCount;
               end
            end
            if (done) begin
               doneCount++;
               lastDoneCycle = cycleCount;
               checkOutput("valid with done", 64'(out_valid), 64'd0);
               if (checkDoneTiming) checkOutput("done latency", 64'(cycleCount), 64'(lastHsCycle + 1));
            end
            prevStall = out_valid && !out_ready;
            prevAddr  = out_addr;
            prevData  = out_data;
            prevLast  = out_last;
         end
      end
   end

   task automatic pushRange(input int lo, input int hi);
      entry_t e;
      for (int k = lo; k <= hi; k++) begin
         e.addr = ADDR_W'(k);
         e.data = 32'h1000_0000 + 32'(k);
         e.last = (k == 31);
         expQ.push_back(e);
      end
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      startCycle = cycleCount - 1;
   endtask

   task automatic checkAllZero(input string tag);
      @(negedge clk);
      checkOutput({tag, " rf_raddr"}, 64'(rf_raddr), 64'd0);
      checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd0);
      checkOutput({tag, " out_addr"}, 64'(out_addr), 64'd0);
      checkOutput({tag, " out_data"}, 64'(out_data), 64'd0);
      checkOutput({tag, " out_last"}, 64'(out_last), 64'd0);
      checkOutput({tag, " busy"}, 64'(busy), 64'd0);
      checkOutput({tag, " done"}, 64'(done), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic waitValidAddr(input int addr, output bit found);
      int budget;
      budget = 0;
      found  = 1'b0;
      while (!(out_valid && out_addr == ADDR_W'(addr)) && budget < 200) begin
         @(posedge clk);
         #1;
         budget++;
      end
      found = out_valid && out_addr == ADDR_W'(addr);
      if (!found) checkOutput("wait for address timeout", 64'd0, 64'(addr));
   endtask

   task automatic waitDone(input int d0);
      int budget;
      budget = 0;
      while (doneCount == d0 && budget < 400) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (doneCount == d0) checkOutput("done timeout", 64'd0, 64'd1);
   endtask

   // Full 32-entry scan; mode 1 adds random backpressure, a 10-cycle stall
   // at address 5 and an ignored start pulse at address 7
   task automatic applyStimulus(input int mode);
      int d0;
      int budget;
      int hold;
      bit restarted;
      d0        = doneCount;
      budget    = 0;
      hold      = 0;
      restarted = 1'b0;
      pushRange(0, 31);
      checkDoneTiming = 1'b1;
      out_ready = (mode == 0);
      pulseStart();
      while (doneCount == d0 && budget < 400) begin
         if (mode == 1) begin
            if (out_valid && out_addr == 5 && hold < 10) begin
               out_ready = 1'b0;
               hold++;
            end else begin
               out_ready = 1'($urandom_range(0, 1));
            end
            if (out_valid && out_addr == 7 && !restarted) begin
               start = 1'b1;
               restarted = 1'b1;
            end else begin
               start = 1'b0;
            end
         end
         @(posedge clk);
         #1;
         budget++;
      end
      start = 1'b0;
      if (doneCount == d0) checkOutput("done timeout", 64'd0, 64'd1);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      checkOutput("scan queue empty", 64'(expQ.size()), 64'd0);
      checkOutput("done pulse count", 64'(doneCount - d0), 64'd1);
      checkDoneTiming = 1'b0;
      out_ready = 1'b0;
   endtask

   // Watchdog
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus
   initial begin
      int  d0;
      int  validHigh;
      bit  found;
      for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + 32'(k);

      // Reset and idle
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkAllZero("reset");
      validHigh = 0;
      repeat (100) begin
         @(negedge clk);
         if (out_valid) validHigh++;
      end
      checkOutput("idle valid cycles", 64'(validHigh), 64'd0);
      @(posedge clk);
      #1;

      // Full scan with ready held high
      $display("[TB] full scan, ready high");
      applyStimulus(0);

      // Backpressure plus ignored start while busy
      $display("[TB] full scan, backpressure");
      applyStimulus(1);

      // Abort in SEND at address 12
      $display("[TB] abort at address 12");
      d0 = doneCount;
      pushRange(0, 11);
      out_ready = 1'b1;
      pulseStart();
      waitValidAddr(12, found);
      abort = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      checkOutput("abort out_valid", 64'(out_valid), 64'd0);
      checkOutput("abort busy", 64'(busy), 64'd0);
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      checkOutput("abort no done", 64'(doneCount - d0), 64'd0);
      checkOutput("abort queue empty", 64'(expQ.size()), 64'd0);

      // Restart after abort begins again at address 0
      $display("[TB] restart after abort");
      applyStimulus(0);

      // Reset at address 20
      $display("[TB] reset at address 20");
      pushRange(0, 19);
      out_ready = 1'b1;
      pulseStart();
      waitValidAddr(20, found);
      rst = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkAllZero("mid-scan reset");
      checkOutput("reset queue empty", 64'(expQ.size()), 64'd0);

`ifdef REGDUMP_SKIP_ZERO_EN
      // Skip-zero: only registers 3 and 31 are nonzero
      $display("[TB] skip-zero sparse file");
      for (int k = 0; k < 32; k++) regs[k] = '0;
      regs[3]  = 32'hAAAA_0003;
      regs[31] = 32'h5555_001F;
      expQ.push_back('{addr: 5'd3, data: 32'hAAAA_0003, last: 1'b0});
      expQ.push_back('{addr: 5'd31, data: 32'h5555_001F, last: 1'b1});
      checkDoneTiming = 1'b1;
      d0 = doneCount;
      out_ready = 1'b1;
      pulseStart();
      waitDone(d0);
      checkDoneTiming = 1'b0;
      checkOutput("sparse queue empty", 64'(expQ.size()), 64'd0);

      // Skip-zero: all-zero file gives no entries and done 33 cycles on
      $display("[TB] skip-zero empty file");
      regs[3]  = '0;
      regs[31] = '0;
      d0 = doneCount;
      pulseStart();
      waitDone(d0);
      checkOutput("empty file done delay", 64'(lastDoneCycle - startCycle), 64'd33);
      checkOutput("empty file queue", 64'(expQ.size()), 64'd0);
      out_ready = 1'b0;
`endif

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential register-file reader that scans the MIPS register file through a dedicated read port and streams every entry out as an (address, data) pair over a valid/ready handshake. It sits beside the register file as the read-side debug counterpart to the write-address path, driving its own read address and consuming the combinational read data. A scan is started by a one-cycle `start` pulse, and completion is signalled by a one-cycle `done` pulse.

## Interface
- `ADDR_W`, default 5: register address width. The scan covers addresses 0 .. 2^ADDR_W-1.
- `DATA_W`, default 32: register data width.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle scan request; taken only in IDLE.
- `abort`  in  1  cancels an active scan; honoured in any state.
- `rf_raddr`  out  ADDR_W  read address to the register file.
- `rf_rdata`  in  DATA_W  combinational read data for `rf_raddr`.
- `out_valid`  out  1  stream entry valid.
- `out_ready`  in  1  consumer ready.
- `out_addr`  out  ADDR_W  address of the current entry.
- `out_data`  out  DATA_W  data of the current entry.
- `out_last`  out  1  set with the entry at address 2^ADDR_W-1.
- `busy`  out  1  high in READ and SEND.
- `done`  out  1  one-cycle pulse at the end of a scan.

## Operation
The FSM has four states: IDLE, READ, SEND, DONE. There is an internal scan pointer `ptr` of ADDR_W bits.

- **IDLE**
  - `start`=1: `ptr` is set to 0 and the FSM moves to READ.
  - `start` is ignored in every other state.
- **READ**
  - `rf_raddr` = `ptr`.
  - At the clock edge, `out_data` <= `rf_rdata`, `out_addr` <= `ptr`, `out_last` <= (`ptr` == all-ones), and the FSM moves to SEND.
- **SEND**
  - `out_valid`=1.
  - `out_ready`=1 with `ptr` == all-ones: the FSM moves to DONE.
  - `out_ready`=1 otherwise: `ptr` <= `ptr`+1 and the FSM moves to READ.
  - `out_ready`=0: the FSM stays in SEND. `out_addr`, `out_data` and `out_last` hold stable.
- **DONE**
  - `done`=1 for exactly one cycle, then the FSM moves to IDLE.
- **Pointer arithmetic**
  - `ptr` increments modulo 2^ADDR_W.
  - Wrap-around never happens, because the all-ones pointer value exits to DONE.
- **`abort`**
  - The next state is IDLE, and `out_valid` drops on the next cycle. This is the only permitted withdrawal of a pending valid.
  - No `done` pulse is produced.
  - `abort` takes priority over `out_ready`.
  - `abort` together with `start` in IDLE: the FSM stays in IDLE.
- **Reset, including mid-scan**
  - The FSM returns to IDLE and `ptr`=0.
  - All outputs are 0: `rf_raddr`, `out_valid`, `out_addr`, `out_data`, `out_last`, `busy`, `done`.
- **`rf_raddr` outside READ**
  - `rf_raddr` holds `ptr`, which is 0 in IDLE after reset.

## Timing
- A `start` sampled at edge N gives READ in cycle N+1 and `out_valid` high from cycle N+2.
- With `out_ready` held high, the throughput is one entry per 2 cycles.
- A full 32-entry scan takes 64 cycles from the first READ to the last handshake. `done` follows in the next cycle.
- `done` and `out_valid` are never high in the same cycle.
- `busy` is high exactly while in READ or SEND.
- All outputs are registered except `rf_raddr`, which is a direct copy of `ptr`.

## Configuration
Macro: `REGDUMP_SKIP_ZERO_EN`.

Defined:
- In READ, if `rf_rdata` == 0, no entry is captured and SEND is skipped.
  - If `ptr` is not all-ones, `ptr` increments and the FSM stays in READ.
  - If `ptr` is all-ones, the FSM moves to DONE.
- A skipped final register means no entry carries `out_last`. `done` still pulses.
- An all-zero file produces no entries and gives `done` 2^ADDR_W+1 cycles after `start`.

Undefined:
- Every address is emitted, including zero-valued registers.

## Test plan
- **Reset and idle:** after `rst` high for 2 cycles, all outputs are 0. With `start` held low, `out_valid` stays 0 for 100 cycles.
- **Full scan, `out_ready`=1:** register k holds 0x1000_0000+k; pulse `start`.
  - Exactly 32 handshakes occur, with `out_addr` 0..31 and `out_data` 0x1000_0000..0x1000_001F.
  - `out_last` is high only with address 31.
  - `done` pulses once, the cycle after the last handshake.
- **Backpressure:** toggle `out_ready` randomly, including holding it low for 10 cycles at address 5.
  - `out_addr`/`out_data` stay stable while `out_valid` & !`out_ready`.
  - No entry is duplicated or dropped.
- **Abort mid-scan:** assert `abort` in SEND at address 12.
  - `out_valid`=0 and `busy`=0 on the next cycle; no `done`.
  - A following `start` restarts at address 0.
- **Start while busy and reset mid-scan:**
  - A `start` pulse at address 7 is ignored and the scan continues normally.
  - `rst` at address 20 returns all outputs to 0 in the next cycle.
- **`REGDUMP_SKIP_ZERO_EN` defined:** only registers 3 and 31 are nonzero.
  - Exactly 2 entries are emitted, address 3 then address 31, with `out_last` high on the second.
  - With an all-zero file there are 0 entries and `done` arrives 33 cycles after `start`.
